// File: rtl/flag_branch_unit_pkg.sv
// Shared constants for the flag/branch unit: ALU opcodes, condition codes,
// flag bit positions, FSM state encoding and the captured-branch record.
package flag_branch_unit_pkg;

  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRA = 4'b0010;
  localparam logic [3:0] OP_ROR = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1011;

  localparam logic [2:0] CC_NZ = 3'b000;
  localparam logic [2:0] CC_Z  = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_V  = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [2:0] MASK_ALL = 3'b111;
  localparam logic [2:0] MASK_Z   = 3'b100;
  localparam logic [2:0] MASK_NONE = 3'b000;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;

  typedef struct packed {
    logic [2:0]  cond;
    logic        is_reg;
    logic [15:0] pc;
    logic [8:0]  imm;
    logic [15:0] rs;
  } br_req_t;

  // Which flag bits an opcode is allowed to overwrite.
  function automatic logic [2:0] flag_write_mask(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB:                 return MASK_ALL;
      OP_SLL, OP_SRA, OP_ROR, OP_XOR: return MASK_Z;
      default:                        return MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/flag_branch_unit_cond.sv
// Combinational branch-condition evaluator over the {Z,V,N} flag word.
module branch_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NZ:   taken = ~z;
      CC_Z:    taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GE:   taken = z | (~z & ~n);
      CC_LE:   taken = n | z;
      CC_V:    taken = v;
      CC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register plus a branch resolver that waits for older flag writers
// before deciding a conditional branch and producing its redirect target.
//
// state   | meaning
// IDLE    | ready for a branch request
// WAIT    | branch captured, older flag writer still in flight
// RESOLVE | decide on registered flags, pulse resolve_valid
module flag_branch_unit
  import flag_branch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [2:0]  alu_flags,
  input  logic        pending_flag_wr,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_cond,
  input  logic        br_reg,
  input  logic [15:0] br_pc,
  input  logic [8:0]  br_imm,
  input  logic [15:0] br_rs,
  output logic [2:0]  flags,
  output logic        resolve_valid,
  output logic        taken,
  output logic        redirect,
  output logic [15:0] redirect_pc
);

  logic [1:0]  state;
  logic [2:0]  flags_q;
  logic [2:0]  wr_mask;
  br_req_t     br_q;
  logic [15:0] target;
  logic [15:0] redirect_pc_q;
  logic        cond_true;

  assign wr_mask = ex_valid ? flag_write_mask(ex_op) : MASK_NONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= (flags_q & ~wr_mask) | (alu_flags & wr_mask);
    end
  end

  assign flags    = flags_q;
  assign br_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (br_valid) state <= pending_flag_wr ? ST_WAIT : ST_RESOLVE;
        ST_WAIT:    if (!pending_flag_wr) state <= ST_RESOLVE;
        ST_RESOLVE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Request payload needs no reset; it is only consumed after a valid capture.
  always_ff @(posedge clk) begin
    if (br_ready && br_valid) begin
      br_q.cond   <= br_cond;
      br_q.is_reg <= br_reg;
      br_q.pc     <= br_pc;
      br_q.imm    <= br_imm;
      br_q.rs     <= br_rs;
    end
  end

  branch_cond_eval u_cond (
    .cond  (br_q.cond),
    .flags (flags_q),
    .taken (cond_true)
  );

  assign target = br_q.is_reg ? br_q.rs
                              : br_q.pc + 16'd2 + {{6{br_q.imm[8]}}, br_q.imm, 1'b0};

  // rst gates the pulse so a reset in RESOLVE never leaks a redirect.
  assign resolve_valid = (state == ST_RESOLVE) & ~rst;
  assign taken         = resolve_valid & cond_true;
  assign redirect      = taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_q <= 16'h0000;
    end else if (redirect) begin
      redirect_pc_q <= target;
    end
  end

  assign redirect_pc = redirect ? target : redirect_pc_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a behavioural model of the flag/branch unit.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [2:0]  alu_flags;
  logic        pending_flag_wr;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic        br_reg;
  logic [15:0] br_pc;
  logic [8:0]  br_imm;
  logic [15:0] br_rs;
  logic [2:0]  flags;
  logic        resolve_valid;
  logic        taken;
  logic        redirect;
  logic [15:0] redirect_pc;

  flag_branch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_op           (ex_op),
    .alu_flags       (alu_flags),
    .pending_flag_wr (pending_flag_wr),
    .br_valid        (br_valid),
    .br_ready        (br_ready),
    .br_cond         (br_cond),
    .br_reg          (br_reg),
    .br_pc           (br_pc),
    .br_imm          (br_imm),
    .br_rs           (br_rs),
    .flags           (flags),
    .resolve_valid   (resolve_valid),
    .taken           (taken),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_flags = 0;
  bit m_has   = 1'b0;
  bit m_go    = 1'b0;
  int m_cond = 0, m_pc = 0, m_imm = 0, m_rs = 0, m_last = 0;
  bit m_reg = 1'b0;

  function automatic bit cond_holds(int c, int fl);
    bit z, v, n;
    z = fl[2]; v = fl[1]; n = fl[0];
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int tgt_of(bit is_reg, int pc, int imm, int rs);
    int simm;
    if (is_reg) return rs;
    simm = (imm >= 256) ? imm - 512 : imm;
    return (pc + 2 + 2 * simm) & 32'hFFFF;
  endfunction

  function automatic int next_flags(int fl, int op, int af);
    if (op == 9 || op == 10) return af;
    if (op == 1 || op == 2 || op == 4 || op == 11) return (fl & 3) | (af & 4);
    return fl;
  endfunction

  function automatic bit exp_rv();
    return m_has && m_go && !rst;
  endfunction

  function automatic bit exp_tk();
    return exp_rv() && cond_holds(m_cond, m_flags);
  endfunction

  initial forever begin
    bit tk;
    int tgt;
    @(posedge clk);
    tk  = exp_tk();
    tgt = tgt_of(m_reg, m_pc, m_imm, m_rs);
    if (rst) begin
      m_flags = 0; m_has = 0; m_go = 0; m_last = 0;
    end else begin
      if (tk) m_last = tgt;
      if (m_has && m_go) begin
        m_has = 0;
      end else if (m_has) begin
        if (!pending_flag_wr) m_go = 1;
      end else if (br_valid) begin
        m_has = 1; m_go = !pending_flag_wr;
        m_cond = int'(br_cond); m_reg = br_reg;
        m_pc = int'(br_pc); m_imm = int'(br_imm); m_rs = int'(br_rs);
      end
      if (ex_valid) m_flags = next_flags(m_flags, int'(ex_op), int'(alu_flags));
    end
  end

  initial forever begin
    int e_pc;
    @(negedge clk);
    if (chk_en) begin
      e_pc = exp_tk() ? tgt_of(m_reg, m_pc, m_imm, m_rs) : m_last;
      check("m_br_ready", br_ready, !m_has);
      check("m_flags", flags, m_flags);
      check("m_resolve_valid", resolve_valid, exp_rv());
      check("m_taken", taken, exp_tk());
      check("m_redirect", redirect, exp_tk());
      check("m_redirect_pc", redirect_pc, e_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input bit exv, input logic [3:0] op, input logic [2:0] af,
                       input bit pend, input bit bv, input logic [2:0] cc, input bit rg,
                       input logic [15:0] pc, input logic [8:0] imm, input logic [15:0] rs);
    rst = r; ex_valid = exv; ex_op = op; alu_flags = af; pending_flag_wr = pend;
    br_valid = bv; br_cond = cc; br_reg = rg; br_pc = pc; br_imm = imm; br_rs = rs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit pend);
    drive(0, 0, 4'h0, 3'b000, pend, 0, 3'b000, 0, 16'h0, 9'h0, 16'h0);
  endtask

  task automatic alu(input logic [3:0] op, input logic [2:0] af);
    drive(0, 1, op, af, 0, 0, 3'b000, 0, 16'h0, 9'h0, 16'h0);
  endtask

  logic [3:0] flag_ops [6] = '{4'b1001, 4'b1010, 4'b0001, 4'b0010, 4'b0100, 4'b1011};

  initial begin
    drive(1, 0, 4'h0, 3'b000, 0, 0, 3'b000, 0, 16'h0, 9'h0, 16'h0);
    step();
    chk_en = 1'b1;
    step();
    check("rst_flags", flags, 3'b000);
    check("rst_ready", br_ready, 1'b1);
    check("rst_redirect_pc", redirect_pc, 16'h0000);
    check("rst_resolve_valid", resolve_valid, 1'b0);

    check("model_tgt_neg", tgt_of(0, 32'h0010, 32'h1FE, 0), 32'h000E);
    check("model_tgt_wrap", tgt_of(0, 32'hFFFE, 32'h0FF, 0), 32'h01FE);

    // ADD then XOR
    alu(4'b1001, 3'b111); step();
    check("add_flags", flags, 3'b111);
    alu(4'b1011, 3'b000); step();
    check("xor_flags", flags, 3'b011);

    // B, taken, negative offset
    alu(4'b1001, 3'b100); step();
    drive(0, 0, 4'h0, 3'b000, 0, 1, 3'b001, 0, 16'h0010, 9'h1FE, 16'h0); step();
    check("b_neg_rv", resolve_valid, 1'b1);
    check("b_neg_redirect", redirect, 1'b1);
    check("b_neg_pc", redirect_pc, 16'h000E);
    check("b_neg_ready", br_ready, 1'b0);
    idle(0); step();
    check("b_neg_hold_redirect", redirect, 1'b0);
    check("b_neg_hold_pc", redirect_pc, 16'h000E);
    check("b_neg_ready_back", br_ready, 1'b1);

    // BR waiting on pending writer, SUB clears Z while waiting
    alu(4'b1001, 3'b100); step();
    drive(0, 0, 4'h0, 3'b000, 1, 1, 3'b001, 1, 16'h0, 9'h0, 16'h1234); step();
    check("wait_ready0", br_ready, 1'b0);
    check("wait_rv0", resolve_valid, 1'b0);
    drive(0, 1, 4'b1010, 3'b000, 1, 0, 3'b000, 0, 16'h0, 9'h0, 16'h0); step();
    check("wait_ready1", br_ready, 1'b0);
    check("wait_flags", flags, 3'b000);
    idle(1); step();
    check("wait_ready2", br_ready, 1'b0);
    check("wait_rv2", resolve_valid, 1'b0);
    idle(0); step();
    check("wait_resolve", resolve_valid, 1'b1);
    check("wait_taken", taken, 1'b0);
    check("wait_redirect", redirect, 1'b0);
    check("wait_ready3", br_ready, 1'b0);
    check("wait_pc_held", redirect_pc, 16'h000E);
    idle(0); step();
    check("wait_ready_back", br_ready, 1'b1);

    // wrap-around target
    drive(0, 0, 4'h0, 3'b000, 0, 1, 3'b111, 0, 16'hFFFE, 9'h0FF, 16'h0); step();
    check("wrap_redirect", redirect, 1'b1);
    check("wrap_pc", redirect_pc, 16'h01FE);
    idle(0); step();
    check("wrap_hold_pc", redirect_pc, 16'h01FE);

    // flag write in RESOLVE must not affect decision
    alu(4'b1001, 3'b000); step();
    drive(0, 0, 4'h0, 3'b000, 0, 1, 3'b000, 0, 16'h0100, 9'h004, 16'h0); step();
    alu(4'b1001, 3'b100);
    #1;
    check("res_wr_taken", taken, 1'b1);
    check("res_wr_pc", redirect_pc, 16'h010A);
    step();
    check("res_wr_flags", flags, 3'b100);
    check("res_wr_rv0", resolve_valid, 1'b0);

    // reset while waiting
    alu(4'b1001, 3'b101); step();
    drive(0, 0, 4'h0, 3'b000, 1, 1, 3'b111, 0, 16'h0200, 9'h0, 16'h0); step();
    check("rstw_ready0", br_ready, 1'b0);
    drive(1, 1, 4'b1001, 3'b111, 1, 1, 3'b111, 0, 16'h0200, 9'h0, 16'h0); step();
    check("rstw_rv", resolve_valid, 1'b0);
    check("rstw_flags", flags, 3'b000);
    check("rstw_ready", br_ready, 1'b1);
    idle(0); step();
    check("rstw_no_resolve", resolve_valid, 1'b0);
    check("rstw_pc", redirect_pc, 16'h0000);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 59) == 0);
      ex_valid        = $urandom_range(0, 1);
      ex_op           = $urandom_range(0, 1) ? flag_ops[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      alu_flags       = 3'($urandom_range(0, 7));
      pending_flag_wr = ($urandom_range(0, 2) == 0);
      br_valid        = $urandom_range(0, 1);
      br_cond         = 3'($urandom_range(0, 7));
      br_reg          = $urandom_range(0, 1);
      br_pc           = 16'($urandom_range(0, 65535));
      br_imm          = 9'($urandom_range(0, 511));
      br_rs           = 16'($urandom_range(0, 65535));
      step();
    end

    idle(0); step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
